// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder computing {cout, sum} = a + b + cin,
// DIGIT bits per clock through a reused DIGIT-bit adder slice and a carry flop.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - synchronous active-high reset
//   start - request, sampled only when not busy (IDLE or DONE state)
//   a, b  - WIDTH-bit operands, captured on accepted start
//   cin   - carry-in, captured on accepted start
//   busy  - high while an addition is in progress
//   done  - one-cycle pulse when sum/cout have just been updated
//   sum   - registered WIDTH-bit result, holds between operations
//   cout  - registered carry-out, holds between operations
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;

  // One digit of the addition plus the partial sum with that digit entering
  // from the MSB side. Shifting the concatenation keeps this legal when
  // DIGIT == WIDTH, where psum has no bits left above the digit.
  always_comb begin
    dsum      = {1'b0, areg[DIGIT-1:0]} + {1'b0, breg[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};
    psum_next = WIDTH'({dsum[DIGIT-1:0], psum} >> DIGIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      areg  <= '0;
      breg  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          areg  <= areg >> DIGIT;
          breg  <= breg >> DIGIT;
          psum  <= psum_next;
          carry <= dsum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= psum_next;
            cout  <= dsum[DIGIT];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE gives back-to-back.
          if (start) begin
            areg  <= a;
            breg  <= b;
            carry <= cin;
            psum  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a8, b8;
  logic [2:0] a3, b3;
  logic       cin;
  logic       start8, start84, start3;

  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy84, done84, cout84;
  logic [7:0] sum84;
  logic       busy3, done3, cout3;
  logic [2:0] sum3;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut84 (
    .clk(clk), .rst(rst), .start(start84), .a(a8), .b(b8), .cin(cin),
    .busy(busy84), .done(done84), .sum(sum84), .cout(cout84)
  );

  serial_adder #(.WIDTH(3), .DIGIT(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       c;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cur = 0;

  logic [7:0] sum_s;
  logic       cout_s, done_s, busy_s;

  always_comb begin
    case (cur)
      0:       begin sum_s = sum8;  cout_s = cout8;  done_s = done8;  busy_s = busy8;  end
      1:       begin sum_s = sum84; cout_s = cout84; done_s = done84; busy_s = busy84; end
      default: begin sum_s = {5'b0, sum3}; cout_s = cout3; done_s = done3; busy_s = busy3; end
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %0h expected %0h", name, cur, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    case (cur)
      0:       start8  = v;
      1:       start84 = v;
      default: start3  = v;
    endcase
  endtask

  // Called at a negedge: drives a request and records its expected result.
  task automatic start_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input logic [7:0] es, input logic ec);
    exp_t e;
    a8 = ia; b8 = ib; a3 = ia[2:0]; b3 = ib[2:0]; cin = ic;
    set_start(1'b1);
    e.s = es; e.c = ec;
    sb.push_back(e);
  endtask

  // Waits for done; start stays high (with operands zeroed) for 'hold' cycles.
  task automatic wait_done(input int n, input int hold, input bit single);
    int   cyc;
    int   bc;
    exp_t e;
    cyc = 0; bc = 0;
    @(negedge clk);
    while (!done_s && cyc < 4 * n + 10) begin
      if (cyc >= hold) set_start(1'b0);
      else begin a8 = '0; b8 = '0; a3 = '0; b3 = '0; end
      if (busy_s) bc++;
      @(negedge clk);
      cyc++;
    end
    set_start(1'b0);
    check("done_seen", done_s, 1);
    check("latency", cyc, n);
    check("busy_cycles", bc, n);
    check("busy_low_at_done", busy_s, 0);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("sum", sum_s, e.s);
      check("cout", cout_s, e.c);
      if (single) begin
        @(negedge clk);
        check("done_single_pulse", done_s, 0);
        check("sum_held", sum_s, e.s);
        check("cout_held", cout_s, e.c);
      end
    end
  endtask

  initial begin
    int stale;
    logic [6:0] vv;
    logic [3:0] tot;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[4] = '{8'h3C, 8'h4B, 1'b0, 8'h87, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst = 1'b1; start8 = 0; start84 = 0; start3 = 0;
    a8 = '0; b8 = '0; a3 = '0; b3 = '0; cin = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      cur = d; #1;
      check("reset_busy", busy_s, 0);
      check("reset_done", done_s, 0);
      check("reset_sum", sum_s, 0);
      check("reset_cout", cout_s, 0);
    end

    // Table of vectors on WIDTH=8 with DIGIT=1 (N=8) and DIGIT=4 (N=2).
    for (int d = 0; d < 2; d++) begin
      cur = d;
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
        start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);
        wait_done((d == 0) ? 8 : 2, 0, 1'b1);
      end
    end

    // Back-to-back: second request issued in the DONE cycle.
    cur = 0;
    @(negedge clk);
    start_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    wait_done(8, 0, 1'b0);
    start_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    wait_done(8, 0, 1'b1);

    // Start held high with operands changed during RUN: no restart.
    @(negedge clk);
    start_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    wait_done(8, 5, 1'b1);

    // rst has priority over start.
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; start8 = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    check("rst_prio_busy", busy8, 0);
    @(negedge clk);
    check("rst_prio_busy_after", busy8, 0);
    check("rst_prio_sum", sum8, 0);

    // Reset on the 4th RUN cycle of FF + FF.
    start_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_sum", sum8, 0);
    check("abort_cout", cout8, 0);
    stale = 0;
    repeat (16) begin
      @(negedge clk);
      if (done8) stale++;
    end
    check("abort_no_stale_done", stale, 0);

    // Exhaustive WIDTH=3 sweep.
    cur = 2;
    @(negedge clk);
    for (int unsigned v = 0; v < 128; v++) begin
      vv  = 7'(v);
      tot = {1'b0, vv[6:4]} + {1'b0, vv[3:1]} + {3'b0, vv[0]};
      start_op({5'b0, vv[6:4]}, {5'b0, vv[3:1]}, vv[0], {5'b0, tot[2:0]}, tot[3]);
      wait_done(3, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
